// File: rtl/xoodyak_vector_sequencer.sv
// xoodyak_vector_sequencer: walks NVEC test vectors from an external
// combinational ROM through xoodyaktop. For each vector it loads the fields,
// pulses dut_start and waits for dut_done. It then compares the result against
// the ROM's expected ciphertext/plaintext and tag, and counts passes and fails.
//
// Modes (latched at run): 00 encrypt, 01 decrypt, 10 encrypt then decrypt
// (round trip, the decrypt input is the captured ciphertext), 11 treated as 00.
//
// Build option: define XSEQ_STOP_ON_FAIL_EN to end the pass at the first
// failing vector (mismatch or timeout) after it has been counted.
//
// Handshake with the DUT: dut_start is a one-cycle request issued only in
// START. The DUT's dut_done is accepted only while in WAIT, and never in the
// same cycle as START. dut_textout and dut_authdata are captured on that cycle.
// A WAIT lasting TIMEOUT cycles without dut_done fails the vector.
//
// state_dbg exposes the FSM encoding for checkers.

module xoodyak_vector_sequencer #(
    parameter int NVEC    = 4,
    parameter int TEXT_W  = 192,
    parameter int KEY_W   = 128,
    parameter int TAG_W   = 128,
    parameter int TIMEOUT = 1023,
    localparam int IW     = $clog2(NVEC) + 1
) (
    input  logic              eph1,
    input  logic              reset,
    input  logic              run,
    input  logic [1:0]        mode_sel,
    output logic [IW-1:0]     vec_idx,
    input  logic [KEY_W-1:0]  vec_key,
    input  logic [KEY_W-1:0]  vec_nonce,
    input  logic [KEY_W-1:0]  vec_ad,
    input  logic [TEXT_W-1:0] vec_pt,
    input  logic [TEXT_W-1:0] vec_ct,
    input  logic [TAG_W-1:0]  vec_tag,
    output logic              dut_start,
    output logic [TEXT_W-1:0] dut_textin,
    output logic [KEY_W-1:0]  dut_key,
    output logic [KEY_W-1:0]  dut_nonce,
    output logic [KEY_W-1:0]  dut_assodata,
    output logic              dut_opmode,
    input  logic [TEXT_W-1:0] dut_textout,
    input  logic [TAG_W-1:0]  dut_authdata,
    input  logic              dut_done,
    output logic              busy,
    output logic              done,
    output logic [IW-1:0]     pass_cnt,
    output logic [IW-1:0]     fail_cnt,
    output logic [IW-1:0]     first_fail,
    output logic              timeout_err,
    output logic [2:0]        state_dbg
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              state;
    logic [1:0]          mode_q;     // mode latched for the whole pass
    logic                phase;      // round trip: 0 encrypt phase, 1 decrypt phase
    logic [CW-1:0]       wait_cnt;
    logic [TEXT_W-1:0]   cap_text;
    logic [TAG_W-1:0]    cap_tag;
    logic                vec_fail;   // current vector failed, consumed in NEXT

    logic [TEXT_W-1:0]   text_exp;
    logic                check_ok;
    logic                last_vec;
    logic                stop_now;

    // Expected text depends on the direction actually issued to the DUT.
    assign text_exp  = dut_opmode ? vec_pt : vec_ct;
    assign check_ok  = (cap_text == text_exp) && (cap_tag == vec_tag);
    assign last_vec  = (vec_idx == IW'(NVEC - 1));
    assign state_dbg = state;

`ifdef XSEQ_STOP_ON_FAIL_EN
    assign stop_now = vec_fail;
`else
    assign stop_now = 1'b0;
`endif

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            mode_q       <= 2'b00;
            phase        <= 1'b0;
            wait_cnt     <= '0;
            cap_text     <= '0;
            cap_tag      <= '0;
            vec_fail     <= 1'b0;
            vec_idx      <= '0;
            dut_start    <= 1'b0;
            dut_textin   <= '0;
            dut_key      <= '0;
            dut_nonce    <= '0;
            dut_assodata <= '0;
            dut_opmode   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            first_fail   <= '1;
            timeout_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (run) begin
                        pass_cnt    <= '0;
                        fail_cnt    <= '0;
                        first_fail  <= '1;
                        timeout_err <= 1'b0;
                        vec_idx     <= '0;
                        mode_q      <= (mode_sel == 2'b11) ? 2'b00 : mode_sel;
                        phase       <= 1'b0;
                        vec_fail    <= 1'b0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    dut_key      <= vec_key;
                    dut_nonce    <= vec_nonce;
                    dut_assodata <= vec_ad;
                    dut_opmode   <= (mode_q == 2'b01) || phase;
                    if (mode_q == 2'b01) begin
                        dut_textin <= vec_ct;
                    end else if (phase) begin
                        dut_textin <= cap_text;
                    end else begin
                        dut_textin <= vec_pt;
                    end
                    dut_start    <= 1'b1;
                    state        <= S_START;
                end
                S_START: begin
                    dut_start <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (dut_done) begin
                        cap_text <= dut_textout;
                        cap_tag  <= dut_authdata;
                        state    <= S_CHECK;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        vec_fail    <= 1'b1;
                        state       <= S_NEXT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (check_ok && (mode_q == 2'b10) && !phase) begin
                        phase <= 1'b1;
                        state <= S_LOAD;
                    end else begin
                        vec_fail <= !check_ok;
                        state    <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (vec_fail) begin
                        fail_cnt <= fail_cnt + 1'b1;
                        if (fail_cnt == '0) begin
                            first_fail <= vec_idx;
                        end
                    end else begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end
                    phase    <= 1'b0;
                    vec_fail <= 1'b0;
                    if (last_vec || stop_now) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        vec_idx <= vec_idx + 1'b1;
                        state   <= S_LOAD;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xoodyak_vector_sequencer.sv
// Bench for xoodyak_vector_sequencer: random ROM contents, a behavioural
// xoodyaktop model, and a scoreboard of expected start requests and pass results.

module tb_xoodyak_vector_sequencer;

    localparam int NVEC = 4;
    localparam int TW   = 192;
    localparam int KW   = 128;
    localparam int GW   = 128;
    localparam int TO   = 1023;
    localparam int DLY  = 20;
    localparam int IW   = $clog2(NVEC) + 1;
    localparam int SW   = 1 + TW + 3 * KW + IW;
    localparam int RW   = 3 * IW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT ----------------
    logic            run = 1'b0;
    logic [1:0]      mode_sel = 2'b00;
    logic [IW-1:0]   vec_idx;
    logic [KW-1:0]   vec_key, vec_nonce, vec_ad;
    logic [TW-1:0]   vec_pt, vec_ct;
    logic [GW-1:0]   vec_tag;
    logic            dut_start;
    logic [TW-1:0]   dut_textin;
    logic [KW-1:0]   dut_key, dut_nonce, dut_assodata;
    logic            dut_opmode;
    logic [TW-1:0]   dut_textout;
    logic [GW-1:0]   dut_authdata;
    logic            dut_done;
    logic            busy, done, timeout_err;
    logic [IW-1:0]   pass_cnt, fail_cnt, first_fail;
    logic [2:0]      state_dbg;

    xoodyak_vector_sequencer #(
        .NVEC(NVEC), .TEXT_W(TW), .KEY_W(KW), .TAG_W(GW), .TIMEOUT(TO)
    ) dut (
        .eph1(clk), .reset(rst), .run(run), .mode_sel(mode_sel),
        .vec_idx(vec_idx), .vec_key(vec_key), .vec_nonce(vec_nonce), .vec_ad(vec_ad),
        .vec_pt(vec_pt), .vec_ct(vec_ct), .vec_tag(vec_tag),
        .dut_start(dut_start), .dut_textin(dut_textin), .dut_key(dut_key),
        .dut_nonce(dut_nonce), .dut_assodata(dut_assodata), .dut_opmode(dut_opmode),
        .dut_textout(dut_textout), .dut_authdata(dut_authdata), .dut_done(dut_done),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail(first_fail), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    // ---------------- vector ROM ----------------
    logic [KW-1:0] rom_key[8], rom_nonce[8], rom_ad[8];
    logic [TW-1:0] rom_pt[8], rom_ct[8];
    logic [GW-1:0] rom_tag[8];

    assign vec_key   = rom_key[vec_idx];
    assign vec_nonce = rom_nonce[vec_idx];
    assign vec_ad    = rom_ad[vec_idx];
    assign vec_pt    = rom_pt[vec_idx];
    assign vec_ct    = rom_ct[vec_idx];
    assign vec_tag   = rom_tag[vec_idx];

    function automatic logic [TW-1:0] rnd_bits();
        logic [TW-1:0] x;
        for (int w = 0; w < TW / 32; w++) x[w*32 +: 32] = $urandom();
        return x;
    endfunction

    task automatic fill_rom(input bit spec_v0);
        for (int v = 0; v < 8; v++) begin
            rom_key[v]   = KW'(rnd_bits());
            rom_nonce[v] = KW'(rnd_bits());
            rom_ad[v]    = KW'(rnd_bits());
            rom_pt[v]    = rnd_bits();
            rom_ct[v]    = rnd_bits();
            rom_tag[v]   = GW'(rnd_bits());
        end
        if (spec_v0) begin
            rom_key[0]   = 128'h303132333435363738393a3b3c3d3e3f;
            rom_nonce[0] = 128'h4142434445464748494a4b4c4d4e4f50;
            rom_ad[0]    = 128'h6162636465666768696a6b6c6d6e6f70;
            rom_pt[0]    = 192'h4142434445464748494a4b4c4d4e4f505152535455565758;
        end
    endtask

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [SW-1:0] exp_q[$];
    int            gap_q[$];
    logic [RW-1:0] res_q[$];
    int            starts_seen = 0;

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural xoodyaktop model ----------------
    int   corrupt_vec = -1;   // tag bit0 flipped on every response for this vector
    int   hang_vec    = -1;   // never answers for this vector
    bit   stray_en    = 1'b0; // drive dut_done high whenever no answer is pending

    initial begin : model
        int            m_idx;
        logic          m_op;
        logic [TW-1:0] m_text;
        dut_done = 1'b0; dut_textout = '0; dut_authdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dut_done = stray_en;
            end else if (dut_start) begin
                m_op = dut_opmode; m_text = dut_textin; m_idx = int'(vec_idx);
                @(posedge clk); #1;
                dut_done = 1'b0;
                if (m_idx == hang_vec) begin
                    repeat (TO + 1) @(negedge clk);
                    dut_done = stray_en;
                end else begin
                    repeat (DLY) @(negedge clk);
                    // a real cipher gives the matching text only for the matching input
                    if (!m_op) dut_textout = (m_text == rom_pt[m_idx]) ? rom_ct[m_idx] : ~rom_ct[m_idx];
                    else       dut_textout = (m_text == rom_ct[m_idx]) ? rom_pt[m_idx] : ~rom_pt[m_idx];
                    dut_authdata = rom_tag[m_idx] ^ GW'(m_idx == corrupt_vec);
                    dut_done = 1'b1;
                    @(negedge clk);
                    dut_done = stray_en; dut_textout = '0; dut_authdata = '0;
                end
            end else begin
                dut_done = stray_en;
            end
        end
    end

    // ---------------- reference model of a whole pass ----------------
    task automatic push_start(input logic op, input logic [TW-1:0] text, input int v, input int gap);
        exp_q.push_back({op, text, rom_key[v], rom_nonce[v], rom_ad[v], IW'(v)});
        gap_q.push_back(gap);
    endtask

    task automatic push_pass(input int mode, input int corrupt, input int hang, input int nrun);
        int m, pc, fc, ff, gap;
        bit to, stopped, bad;
        m = (mode == 3) ? 0 : mode;
        pc = 0; fc = 0; ff = -1; gap = -1; to = 0; stopped = 0;
        for (int v = 0; v < nrun && !stopped; v++) begin
            bad = (v == corrupt) || (v == hang);
            if (m == 1) push_start(1'b1, rom_ct[v], v, gap);
            else        push_start(1'b0, rom_pt[v], v, gap);
            if (v == hang) begin
                to = 1; gap = TO + 3;
            end else if (m == 2 && !bad) begin
                push_start(1'b1, rom_ct[v], v, DLY + 3);
                gap = DLY + 4;
            end else begin
                gap = DLY + 4;
            end
            if (bad) begin
                fc++;
                if (ff < 0) ff = v;
`ifdef XSEQ_STOP_ON_FAIL_EN
                stopped = 1;
`endif
            end else begin
                pc++;
            end
        end
        if (nrun == NVEC)
            res_q.push_back({IW'(pc), IW'(fc), (ff < 0) ? {IW{1'b1}} : IW'(ff), to});
    endtask

    // ---------------- monitors ----------------
    initial begin : start_mon
        int   last_cyc;
        logic prev_start;
        logic [SW-1:0] e;
        int   g;
        last_cyc = 0; prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && dut_start) begin
                starts_seen++;
                check("start_width", prev_start, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_start", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    g = gap_q.pop_front();
                    check("start_fields", {dut_opmode, dut_textin, dut_key, dut_nonce, dut_assodata, vec_idx}, e);
                    if (g >= 0) check("start_gap", cyc - last_cyc, g);
                end
                last_cyc = cyc;
            end
            prev_start = dut_start && !rst;
        end
    end

    initial begin : result_mon
        logic done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && done && !done_prev) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 1'b1, 1'b0);
                end else begin
                    check("pass_result", {pass_cnt, fail_cnt, first_fail, timeout_err}, res_q.pop_front());
                    check("busy_in_done", busy, 1'b0);
                end
            end
            done_prev = done && !rst;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_pass(input int mode);
        @(negedge clk);
        mode_sel = 2'(mode);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        mode_sel = 2'($urandom_range(0, 3));
        check("cleared_after_run", {busy, done, pass_cnt, fail_cnt, timeout_err, first_fail},
              {1'b1, 1'b0, {IW{1'b0}}, {IW{1'b0}}, 1'b0, {IW{1'b1}}});
    endtask

    task automatic wait_pass(input string name);
        int n = 0;
        while (!done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check(name, done, 1'b1);
        @(negedge clk);
        check("queues_drained", {exp_q.size(), res_q.size()}, 64'd0);
    endtask

    task automatic full_pass(input string name, input int mode, input int corrupt, input int hang);
        fill_rom(1'b0);
        corrupt_vec = corrupt; hang_vec = hang;
        push_pass(mode, corrupt, hang, NVEC);
        start_pass(mode);
        wait_pass(name);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int base, n;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {pass_cnt, fail_cnt, first_fail, timeout_err, done, busy, dut_start, dut_opmode, vec_idx},
              {{IW{1'b0}}, {IW{1'b0}}, {IW{1'b1}}, 4'b0000, 1'b0, {IW{1'b0}}});
        check("reset_data", {dut_textin, dut_key}, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // encrypt, known vector 0 fields
        fill_rom(1'b1);
        corrupt_vec = -1; hang_vec = -1;
        push_pass(0, -1, -1, NVEC);
        start_pass(0);
        wait_pass("enc_pass");

        full_pass("dec_corrupt", 1, 2, -1);
        full_pass("roundtrip", 2, -1, -1);
        full_pass("roundtrip_fail", 2, 1, -1);
        full_pass("reserved_mode", 3, $urandom_range(0, 3), -1);

        // timeout on vector 1 with stray done pulses outside WAIT
        stray_en = 1'b1;
        full_pass("timeout", 0, -1, 1);
        @(negedge clk);
        stray_en = 1'b0;
        repeat (2) @(negedge clk);

        // run pulsed while busy (with a different mode) must be ignored
        fill_rom(1'b0);
        corrupt_vec = -1; hang_vec = -1;
        push_pass(0, -1, -1, NVEC);
        start_pass(0);
        repeat (30) @(negedge clk);
        mode_sel = 2'b01; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("busy_mid_pass", busy, 1'b1);
        wait_pass("run_while_busy");

        // reset during WAIT of vector 2
        fill_rom(1'b0);
        push_pass(0, -1, -1, 3);
        base = starts_seen;
        start_pass(0);
        n = 0;
        while (starts_seen < base + 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reached_vec2", starts_seen - base, 3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_mid_wait",
              {pass_cnt, fail_cnt, first_fail, timeout_err, done, busy, dut_start, vec_idx},
              {{IW{1'b0}}, {IW{1'b0}}, {IW{1'b1}}, 3'b000, 1'b0, {IW{1'b0}}});
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("flushed_after_reset", {exp_q.size(), res_q.size()}, 64'd0);
        full_pass("restart_after_reset", 0, $urandom_range(0, 3), -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
